// File: rtl/alu_op_sequencer.sv
// Self-test initiator for the small ALU: drives one op, waits for it to
// settle, checks the result against a locally computed golden value.
module alu_op_sequencer #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_ins,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic [1:0]           alu_ins,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_s,
  input  logic                 alu_ov,
  input  logic                 alu_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_s,
  output logic                 rsp_ov,
  output logic                 rsp_cout,
  output logic                 rsp_mismatch,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESPOND
  } state_e;

  state_e            state_q;
  logic [SW-1:0]     cnt_q;
  logic [1:0]        ins_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  gs_q;
  logic              gov_q;
  logic              gc_q;
  logic [WIDTH-1:0]  rs_q;
  logic              rov_q;
  logic              rc_q;
  logic              rmm_q;
  logic [CNT_WIDTH-1:0] pass_q;
  logic [CNT_WIDTH-1:0] fail_q;

  logic              sub_d;
  logic [WIDTH-1:0]  opb_d;
  logic [WIDTH:0]    sum_d;
  logic [WIDTH-1:0]  gs_d;
  logic              gov_d;
  logic              gc_d;
  logic              mm_d;

  // Golden result for the request currently on the input port
  always_comb begin
    sub_d = (req_ins == 2'b01);
    opb_d = sub_d ? ~req_b : req_b;
    sum_d = {1'b0, req_a} + {1'b0, opb_d}
          + {{WIDTH{1'b0}}, sub_d};
    gs_d  = sum_d[WIDTH-1:0];
    gc_d  = sum_d[WIDTH];
    gov_d = (req_a[WIDTH-1] == opb_d[WIDTH-1])
         && (sum_d[WIDTH-1] != req_a[WIDTH-1]);
    if (req_ins[1]) begin
      gs_d  = req_ins[0] ? (req_a | req_b)
                         : (req_a & req_b);
      gc_d  = 1'b0;
      gov_d = 1'b0;
    end
  end

  // Compare the live ALU outputs against the stored golden triple
  always_comb begin
    mm_d = ({alu_s, alu_ov, alu_cout}
         != {gs_q, gov_q, gc_q});
  end

  // Sequencer FSM with registered operand and response outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ins_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gs_q    <= '0;
      gov_q   <= 1'b0;
      gc_q    <= 1'b0;
      rs_q    <= '0;
      rov_q   <= 1'b0;
      rc_q    <= 1'b0;
      rmm_q   <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            ins_q   <= req_ins;
            a_q     <= req_a;
            b_q     <= req_b;
            gs_q    <= gs_d;
            gov_q   <= gov_d;
            gc_q    <= gc_d;
            cnt_q   <= '0;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            rs_q    <= alu_s;
            rov_q   <= alu_ov;
            rc_q    <= alu_cout;
            rmm_q   <= mm_d;
            state_q <= RESPOND;
            if (mm_d) begin
              if (fail_q != CMAX) fail_q <= fail_q + 1'b1;
            end else begin
              if (pass_q != CMAX) pass_q <= pass_q + 1'b1;
            end
          end
        end
        RESPOND: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESPOND);
  assign alu_ins      = ins_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign rsp_s        = rs_q;
  assign rsp_ov       = rov_q;
  assign rsp_cout     = rc_q;
  assign rsp_mismatch = rmm_q;
  assign pass_count   = pass_q;
  assign fail_count   = fail_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 3-bit ALU
// that can be told to corrupt its result.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_ins;
  logic [2:0] req_a;
  logic [2:0] req_b;
  logic [1:0] alu_ins;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [2:0] alu_s;
  logic       alu_ov;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_s;
  logic       rsp_ov;
  logic       rsp_cout;
  logic       rsp_mismatch;
  logic [7:0] pass_count;
  logic [7:0] fail_count;

  logic       fault;
  int         n_chk;
  int         n_bad;
  int         exp_pass;
  int         exp_fail;

  alu_op_sequencer #(
    .WIDTH(3),
    .SETTLE_CYCLES(2),
    .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_ins(req_ins),
    .req_a(req_a),
    .req_b(req_b),
    .alu_ins(alu_ins),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_s(alu_s),
    .alu_ov(alu_ov),
    .alu_cout(alu_cout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_s(rsp_s),
    .rsp_ov(rsp_ov),
    .rsp_cout(rsp_cout),
    .rsp_mismatch(rsp_mismatch),
    .pass_count(pass_count),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Reference ALU using signed integer arithmetic
  always_comb begin
    int sa, sb, sr, ur;
    sa = alu_a[2] ? int'(alu_a) - 8 : int'(alu_a);
    sb = alu_b[2] ? int'(alu_b) - 8 : int'(alu_b);
    sr = 0;
    ur = 0;
    alu_s = '0;
    alu_ov = 1'b0;
    alu_cout = 1'b0;
    case (alu_ins)
      2'b00: begin
        sr = sa + sb;
        ur = int'(alu_a) + int'(alu_b);
        alu_s = 3'(ur);
        alu_cout = (ur > 7);
        alu_ov = (sr > 3) || (sr < -4);
      end
      2'b01: begin
        sr = sa - sb;
        ur = int'(alu_a) + (7 - int'(alu_b)) + 1;
        alu_s = 3'(ur);
        alu_cout = (ur > 7);
        alu_ov = (sr > 3) || (sr < -4);
      end
      2'b10: alu_s = alu_a & alu_b;
      default: alu_s = alu_a | alu_b;
    endcase
    if (fault) alu_s = alu_s ^ 3'b001;
  end

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic count_exp(input bit mm);
    if (mm) begin
      if (exp_fail < 255) exp_fail++;
    end else begin
      if (exp_pass < 255) exp_pass++;
    end
  endtask

  // Present a request and wait for it to be taken (bounded)
  task automatic send(input logic [1:0] ins,
                      input logic [2:0] a,
                      input logic [2:0] b);
    int n;
    req_valid = 1'b1;
    req_ins = ins;
    req_a = a;
    req_b = b;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("alu_ins", int'(alu_ins), int'(ins));
    check("alu_a", int'(alu_a), int'(a));
    check("alu_b", int'(alu_b), int'(b));
    check("busy", int'(req_ready), 0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [1:0] ins,
                       input logic [2:0] a,
                       input logic [2:0] b,
                       input int es,
                       input int eov,
                       input int ec,
                       input bit emm);
    int n;
    send(ins, a, b);
    wait_rsp(n);
    check({tag, "_lat"}, n, 2);
    count_exp(emm);
    check({tag, "_s"}, int'(rsp_s), es);
    check({tag, "_ov"}, int'(rsp_ov), eov);
    check({tag, "_c"}, int'(rsp_cout), ec);
    check({tag, "_mm"}, int'(rsp_mismatch), int'(emm));
    check({tag, "_pass"}, int'(pass_count), exp_pass);
    check({tag, "_fail"}, int'(fail_count), exp_fail);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_drop"}, int'(rsp_valid), 0);
    check({tag, "_idle"}, int'(req_ready), 1);
    check({tag, "_hold"}, int'(rsp_s), es);
  endtask

  initial begin
    int n;
    logic [2:0] held;
    n_chk = 0;
    n_bad = 0;
    exp_pass = 0;
    exp_fail = 0;
    fault = 1'b0;
    resetn = 1'b0;
    req_valid = 1'b0;
    req_ins = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(req_ready), 1);
    check("rst_valid", int'(rsp_valid), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_rsp_s", int'(rsp_s), 0);
    check("rst_pass", int'(pass_count), 0);
    check("rst_fail", int'(fail_count), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    do_op("add", 2'b00, 3'd2, 3'd1, 3, 0, 0, 1'b0);
    do_op("sub", 2'b01, 3'd3, 3'd2, 1, 0, 1, 1'b0);
    do_op("addov", 2'b00, 3'd3, 3'd1, 4, 1, 0, 1'b0);
    do_op("and", 2'b10, 3'd4, 3'd2, 0, 0, 0, 1'b0);
    do_op("or", 2'b11, 3'd4, 3'd2, 6, 0, 0, 1'b0);
    do_op("sub0", 2'b01, 3'd0, 3'd1, 7, 0, 0, 1'b0);
    fault = 1'b1;
    do_op("fault", 2'b00, 3'd2, 3'd1, 2, 0, 0, 1'b1);
    fault = 1'b0;

    // Backpressure with a pending request behind it
    send(2'b10, 3'd7, 3'd5);
    wait_rsp(n);
    check("bp_lat", n, 2);
    count_exp(1'b0);
    held = rsp_s;
    check("bp_s", int'(rsp_s), 5);
    req_valid = 1'b1;
    req_ins = 2'b11;
    req_a = 3'd1;
    req_b = 3'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", int'(rsp_valid), 1);
      check("bp_stable", int'(rsp_s), int'(held));
      check("bp_ready", int'(req_ready), 0);
      check("bp_alu_a", int'(alu_a), 7);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_hs_valid", int'(rsp_valid), 0);
    check("bp_hs_ready", int'(req_ready), 1);
    check("bp_hs_alu_a", int'(alu_a), 7);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_acc_busy", int'(req_ready), 0);
    check("bp_acc_a", int'(alu_a), 1);
    wait_rsp(n);
    check("bp2_lat", n, 2);
    count_exp(1'b0);
    check("bp2_s", int'(rsp_s), 3);
    check("bp2_pass", int'(pass_count), exp_pass);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset while the op is settling
    send(2'b00, 3'd2, 3'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_pass = 0;
    exp_fail = 0;
    check("mr_ready", int'(req_ready), 1);
    check("mr_valid", int'(rsp_valid), 0);
    check("mr_pass", int'(pass_count), 0);
    check("mr_fail", int'(fail_count), 0);
    check("mr_alu_a", int'(alu_a), 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) n++;
    end
    check("mr_no_rsp", n, 0);

    // Counter saturation
    for (int i = 0; i < 257; i++)
      do_op("sat", 2'b00, 3'd1, 3'd1, 2, 0, 0, 1'b0);
    check("sat_pass", int'(pass_count), 255);
    check("sat_fail", int'(fail_count), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator-side counterpart to the 3-bit ALU, which consumes ins/A/B and returns S/OV/Cout.
- Accepts one operation request at a time over a valid/ready handshake and drives the registered operands onto the ALU.
- Waits a programmable settle time, then captures the ALU result and compares it against an internally computed golden result.
- Returns the result over a valid/ready response handshake and keeps pass/fail tallies. Used for on-board self-test of the ALU.

Parameters:
- WIDTH, 3, operand/result width in bits.
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before sampling; legal values 1 and above.
- CNT_WIDTH, 8, width of the pass/fail counters.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_ins  input  2  opcode.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- alu_ins  output  2  opcode driven to ALU.
- alu_a  output  WIDTH  operand A driven to ALU.
- alu_b  output  WIDTH  operand B driven to ALU.
- alu_s  input  WIDTH  ALU sum/result.
- alu_ov  input  1  ALU signed overflow.
- alu_cout  input  1  ALU carry out.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_s  output  WIDTH  captured ALU result.
- rsp_ov  output  1  captured overflow.
- rsp_cout  output  1  captured carry.
- rsp_mismatch  output  1  captured result differs from golden.
- pass_count  output  CNT_WIDTH  matching responses since reset.
- fail_count  output  CNT_WIDTH  mismatching responses since reset.

Behaviour:
- Single clock. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset forces state IDLE. All registered outputs go to 0: alu_*, rsp_*, both counters, and the settle counter. req_ready is 1 in IDLE.
- Opcode encoding:
  - 00 = A+B
  - 01 = A−B, computed as A + ~B + 1
  - 10 = A AND B
  - 11 = A OR B
- Golden result:
  - Arithmetic ops: S is the low WIDTH bits of the result. Cout is bit WIDTH of the (WIDTH+1)-bit sum. OV = (MSB of first operand == MSB of effective second operand) AND (MSB of S != that MSB), where the effective second operand is B for add and ~B for subtract.
  - Logic ops: golden OV = 0 and Cout = 0.
- States: IDLE, DRIVE, RESPOND.
- IDLE:
  - req_ready = 1, rsp_valid = 0.
  - On req_valid at an edge: register req_ins/a/b into alu_ins/a/b, register the golden triple, clear the settle counter, go to DRIVE.
  - With no request, alu_* hold their previous values.
- DRIVE:
  - req_ready = 0; alu_* stable.
  - The settle counter increments each cycle.
  - On the edge where the counter equals SETTLE_CYCLES−1:
    - sample alu_s/ov/cout into rsp_s/ov/cout;
    - set rsp_mismatch = (sampled triple != golden triple);
    - increment pass_count or fail_count;
    - go to RESPOND.
- RESPOND:
  - rsp_valid = 1; rsp_* held stable.
  - On rsp_ready at an edge: go to IDLE. rsp_valid drops the next cycle; rsp_* keep their values.
  - With rsp_ready low, the state holds indefinitely and no new request is accepted.
- Latency: request accepted at edge t gives alu_* valid from t, rsp_valid high from edge t+SETTLE_CYCLES. Throughput is one op per SETTLE_CYCLES+2 cycles with rsp_ready tied high.
- Counters saturate at 2^CNT_WIDTH−1; no wrap.
- Reset asserted in any state overrides everything: the in-flight op is discarded, counters cleared, no response issued.
- req_valid while not in IDLE is ignored (req_ready = 0). Requesters must hold req_valid/data until accepted.
- rsp_ready asserted outside RESPOND has no effect.

Test Plan:
- Add, no overflow: ins=00, A=2, B=1, SETTLE_CYCLES=2 -> alu_a=2/alu_b=1 the cycle after acceptance; rsp_valid 2 cycles after acceptance with rsp_s=3, ov=0, cout=0, mismatch=0; pass_count=1.
- Subtract, then signed overflow: ins=01, A=3, B=2 -> rsp_s=1, cout=1, ov=0. Then ins=00, A=3, B=1 -> rsp_s=4, ov=1, cout=0. pass_count=2.
- Logic ops: ins=10, A=4, B=2 -> rsp_s=0. Then ins=11, A=4, B=2 -> rsp_s=6, ov=0, cout=0. No mismatches.
- Fault injection: ALU model returns S xor 1 on ins=00, A=2, B=1 -> rsp_s=2, rsp_mismatch=1, fail_count=1, pass_count unchanged.
- Backpressure: rsp_ready low for 5 cycles in RESPOND -> rsp_valid stays 1, rsp_* stable, req_ready=0, and a pending req_valid is not accepted until 1 cycle after the rsp_ready handshake.
- Reset mid-DRIVE: assert resetn=0 for one edge during DRIVE -> next cycle IDLE, req_ready=1, rsp_valid=0, counters 0, and no response for the aborted op.
